sym_stream_monitor: RTL and testbench

- Downstream consumer of the 2-bit toggle FSM stage's symbol stream: `sym` is that stage's `out[1:0]` and `symn` is its `outn`.
- Per sample it tracks a sliding window of the last DEPTH symbols, pulses on a programmable symbol pattern, and counts pattern hits and illegal two-bit "jumps".
- Optionally checks the complement bit and flags faults.
- Used as a stream monitor/scoreboard stage in testcase designs.

---
 rtl/sym_stream_monitor.sv | 101 ++++++++++
 tb/tb_sym_stream_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sym_stream_monitor.sv
// sym_stream_monitor: sliding-window pattern and jump monitor for a 2-bit symbol stream.
// Define SYM_CHECK_EN to enable the complement check, err flag and FAULT lockout.
module sym_stream_monitor #(
  parameter int                 DEPTH       = 4,
  parameter logic [2*DEPTH-1:0] PATTERN     = 8'h1E,
  parameter int                 CW          = 8,
  parameter bit                 LOCK_ON_ERR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [1:0]    sym,
  input  logic          symn,
  output logic          hit,
  output logic [CW-1:0] hit_cnt,
  output logic [CW-1:0] jump_cnt,
  output logic          err,
  output logic [1:0]    state
);

  localparam int             FW   = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t             cur, nxt;
  logic [2*DEPTH-1:0] win, win_shift;
  logic [FW-1:0]      fill, fill_inc;
  logic               accept, chk_err, take, jump, match;

  assign accept = en && !clr && (cur != FAULT);

`ifdef SYM_CHECK_EN
  // Upstream reset leaves outn equal to out[0], so WARM skips the check.
  assign chk_err = accept && (cur == RUN) && (symn == sym[0]);
`else
  logic unused_symn;
  assign unused_symn = symn;
  assign chk_err     = 1'b0;
`endif

  assign take      = accept && !(chk_err && LOCK_ON_ERR);
  assign win_shift = {win[2*DEPTH-3:0], sym};
  assign fill_inc  = (fill == FULL) ? fill : fill + 1'b1;
  assign jump      = (fill != '0) && ((sym ^ win[1:0]) == 2'b11);
  assign match     = (fill_inc == FULL) && (win_shift == PATTERN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= WARM;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (clr) begin
      nxt = WARM;
    end else begin
      case (cur)
        WARM:    if (accept) nxt = RUN;
        RUN:     if (chk_err && LOCK_ON_ERR) nxt = FAULT;
        FAULT:   nxt = FAULT;
        default: nxt = WARM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win      <= '0;
      fill     <= '0;
      hit      <= 1'b0;
      hit_cnt  <= '0;
      jump_cnt <= '0;
      err      <= 1'b0;
    end else if (clr) begin
      win      <= '0;
      fill     <= '0;
      hit      <= 1'b0;
      hit_cnt  <= '0;
      jump_cnt <= '0;
      err      <= 1'b0;
    end else begin
      hit <= take && match;
      if (chk_err) err <= 1'b1;
      if (take) begin
        win  <= win_shift;
        fill <= fill_inc;
        if (jump && (jump_cnt != '1)) jump_cnt <= jump_cnt + 1'b1;
        if (match && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_sym_stream_monitor.sv
// Directed bench for sym_stream_monitor: queue-based reference model checked every cycle,
// plus literal expectations. Instance 0 uses defaults, instance 1 uses CW=3, LOCK_ON_ERR=0.
module tb_sym_stream_monitor;

  logic       clk = 1'b0;
  logic       rst, en, clr, symn;
  logic [1:0] sym;

  logic       hit0, err0, hit1, err1;
  logic [7:0] hc0, jc0;
  logic [2:0] hc1, jc1;
  logic [1:0] st0, st1;

  int n_chk  = 0;
  int n_fail = 0;

  int mq0[$];
  int mq1[$];
  int mhit[2], mhc[2], mjc[2], merr[2], mst[2];
  int pat[4] = '{0, 1, 3, 2};

  always #5 clk = ~clk;

  sym_stream_monitor dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sym(sym), .symn(symn),
    .hit(hit0), .hit_cnt(hc0), .jump_cnt(jc0), .err(err0), .state(st0)
  );

  sym_stream_monitor #(.CW(3), .LOCK_ON_ERR(1'b0)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sym(sym), .symn(symn),
    .hit(hit1), .hit_cnt(hc1), .jump_cnt(jc1), .err(err1), .state(st1)
  );

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    mq0.delete();
    mq1.delete();
    for (int i = 0; i < 2; i++) begin
      mhit[i] = 0; mhc[i] = 0; mjc[i] = 0; merr[i] = 0; mst[i] = 0;
    end
  endtask

  // Instance 0 locks on error, instance 1 only flags.
  task automatic model_edge(int i, bit e, bit c, logic [1:0] s, bit sn);
    int  q[$];
    int  maxc;
    bit  bad;
    bit  ok;
    bit  drop;
    maxc = (i == 0) ? 255 : 7;
    if (i == 0) q = mq0; else q = mq1;
    mhit[i] = 0;
    if (c) begin
      q.delete();
      mhc[i] = 0; mjc[i] = 0; merr[i] = 0; mst[i] = 0;
    end else if (e && mst[i] != 2) begin
      bad = 1'b0;
`ifdef SYM_CHECK_EN
      bad = (mst[i] == 1) && (sn == s[0]);
`else
      if (sn) bad = 1'b0;
`endif
      drop = bad && (i == 0);
      if (bad) merr[i] = 1;
      mst[i] = drop ? 2 : 1;
      if (!drop) begin
        if (q.size() > 0 && ((int'(s) ^ q[q.size()-1]) == 3) && mjc[i] < maxc) mjc[i]++;
        q.push_back(int'(s));
        if (q.size() > 4) void'(q.pop_front());
        ok = 1'b0;
        if (q.size() == 4) begin
          ok = 1'b1;
          for (int k = 0; k < 4; k++) if (q[k] != pat[k]) ok = 1'b0;
        end
        if (ok) begin
          mhit[i] = 1;
          if (mhc[i] < maxc) mhc[i]++;
        end
      end
    end
    if (i == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic step(bit e, bit c, logic [1:0] s, bit sn);
    en = e; clr = c; sym = s; symn = sn;
    @(posedge clk);
    model_edge(0, e, c, s, sn);
    model_edge(1, e, c, s, sn);
    #1;
  endtask

  task automatic good(logic [1:0] s);
    step(1'b1, 1'b0, s, ~s[0]);
  endtask

  always @(negedge clk) begin
    chk("hit0", int'(hit0), mhit[0]);
    chk("hit_cnt0", int'(hc0), mhc[0]);
    chk("jump_cnt0", int'(jc0), mjc[0]);
    chk("err0", int'(err0), merr[0]);
    chk("state0", int'(st0), mst[0]);
    chk("hit1", int'(hit1), mhit[1]);
    chk("hit_cnt1", int'(hc1), mhc[1]);
    chk("jump_cnt1", int'(jc1), mjc[1]);
    chk("err1", int'(err1), merr[1]);
    chk("state1", int'(st1), mst[1]);
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; sym = 2'b00; symn = 1'b1;
    mreset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", int'(st0), 0);
    chk("reset_hit_cnt", int'(hc0), 0);

    good(2'b00); good(2'b01); good(2'b11); good(2'b10);
    chk("first_hit", int'(hit0), 1);
    chk("first_hit_cnt", int'(hc0), 1);
    chk("first_jump_cnt", int'(jc0), 0);
    chk("first_state", int'(st0), 1);

    for (int r = 0; r < 2; r++) begin
      good(2'b00); good(2'b01); good(2'b11); good(2'b10);
      chk("repeat_hit", int'(hit0), 1);
    end
    chk("repeat_hit_cnt", int'(hc0), 3);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("idle_hit", int'(hit0), 0);

    step(1'b0, 1'b1, 2'b00, 1'b1);
    chk("clr_hit_cnt", int'(hc0), 0);
    good(2'b00); good(2'b11); good(2'b00);
    chk("jump_cnt_2", int'(jc0), 2);
    chk("jump_nohit", int'(hit0), 0);

    step(1'b0, 1'b1, 2'b00, 1'b1);
    good(2'b00); good(2'b01);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 2'b11, 1'b0);
      chk("paused_hit", int'(hit0), 0);
    end
    good(2'b11); good(2'b10);
    chk("resumed_hit", int'(hit0), 1);
    chk("resumed_hit_cnt", int'(hc0), 1);

    step(1'b1, 1'b0, 2'b01, 1'b1);
`ifdef SYM_CHECK_EN
    chk("err_set", int'(err0), 1);
    chk("fault_state", int'(st0), 2);
    chk("flag_only_state", int'(st1), 1);
    chk("flag_only_err", int'(err1), 1);
`else
    chk("err_tied", int'(err0), 0);
    chk("no_fault_state", int'(st0), 1);
`endif
    good(2'b00); good(2'b01); good(2'b11); good(2'b10);
`ifdef SYM_CHECK_EN
    chk("frozen_hit_cnt", int'(hc0), 1);
    chk("frozen_hit", int'(hit0), 0);
`else
    chk("live_hit", int'(hit0), 1);
`endif
    step(1'b0, 1'b1, 2'b00, 1'b1);
    chk("clr_state", int'(st0), 0);
    chk("clr_err", int'(err0), 0);

    for (int k = 0; k < 10; k++) good((k % 2 == 0) ? 2'b00 : 2'b11);
    chk("jump_cnt_9", int'(jc0), 9);
    chk("jump_cnt_sat", int'(jc1), 7);

    good(2'b00);
    #2 rst = 1'b1;
    mreset();
    #1;
    chk("async_jump_cnt0", int'(jc0), 0);
    chk("async_jump_cnt1", int'(jc1), 0);
    chk("async_state0", int'(st0), 0);
    chk("async_hit_cnt0", int'(hc0), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    good(2'b01);
    good(2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
